// File: rtl/led_pkg.sv
// Shared constants, state encoding and LED word layout for the APA102 strand scheduler.
package led_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned LEN_W    = 5;
   localparam int unsigned HDR_W    = 3;
   localparam int unsigned BRIGHT_W = 5;
   localparam int unsigned COLOR_W  = 8;

   localparam logic [WORD_W-1:0] START_FRAME = 32'h0000_0000;
   localparam logic [WORD_W-1:0] END_FRAME   = 32'hFFFF_FFFF;
   localparam logic [WORD_W-1:0] OFF_LED     = 32'hE000_0000;

   typedef struct packed {
      logic [HDR_W-1:0]    hdr;
      logic [BRIGHT_W-1:0] brightness;
      logic [COLOR_W-1:0]  blue;
      logic [COLOR_W-1:0]  green;
      logic [COLOR_W-1:0]  red;
   } led_word_t;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StFetch,
      StShift,
      StEnd
   } led_state_e;

   // lim is one bit wider than a length so the comparison never folds to a constant.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l,
                                                  input logic [LEN_W:0]   lim);
      if ({1'b0, l} > lim) begin
         return lim[LEN_W-1:0];
      end
      return l;
   endfunction

endpackage

// File: rtl/led_word_shifter.sv
// 32-bit MSB-first serialiser: each bit is SCK_HALF clocks low then SCK_HALF clocks high.
module led_word_shifter
   import led_pkg::*;
#(
   parameter int unsigned SCK_HALF = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   output logic              sck,
   output logic              mosi,
   output logic              word_done
);

   localparam int unsigned CNT_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [4:0]        bit_q, bit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sck_q, sck_d;
   logic              busy_q, busy_d;
   logic              half_end;
   logic              last_bit;

   assign half_end  = (cnt_q == CNT_W'(SCK_HALF - 1));
   assign last_bit  = (bit_q == 5'd31);
   assign word_done = busy_q & sck_q & half_end & last_bit;
   assign sck       = sck_q;
   assign mosi      = shreg_q[WORD_W-1];

   always_comb begin
      shreg_d = shreg_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      sck_d   = sck_q;
      busy_d  = busy_q;
      if (load) begin
         shreg_d = word;
         bit_d   = '0;
         cnt_d   = '0;
         sck_d   = 1'b0;
         busy_d  = 1'b1;
      end else if (busy_q) begin
         if (half_end) begin
            cnt_d = '0;
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               sck_d = 1'b0;
               // The last bit stays on mosi so the line holds while the next word is fetched.
               if (last_bit) begin
                  busy_d = 1'b0;
               end else begin
                  bit_d   = bit_q + 5'd1;
                  shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
               end
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         sck_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         sck_q   <= sck_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: rtl/led_strand_scheduler.sv
// Round-robin scheduler driving several APA102 strands from one shared SPI word shifter.
module led_strand_scheduler
   import led_pkg::*;
#(
   parameter int unsigned NSTRAND  = 3,
   parameter int unsigned SCK_HALF = 64,
   parameter int unsigned MAXLEN   = 31
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NSTRAND-1:0]       req,
   input  logic [LEN_W*NSTRAND-1:0] len,
   input  logic [WORD_W-1:0]        pix_data,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic [LEN_W-1:0]         pix_index,
   output logic [NSTRAND-1:0]       grant,
   output logic                     sck,
   output logic [NSTRAND-1:0]       mosi,
   output logic [NSTRAND-1:0]       done
);

   localparam int unsigned PTR_W = (NSTRAND > 1) ? $clog2(NSTRAND) : 1;
   localparam logic [LEN_W:0] LEN_LIM = (LEN_W + 1)'(MAXLEN);

   led_state_e         state_q, state_d;
   logic [NSTRAND-1:0] grant_q, grant_d;
   logic [NSTRAND-1:0] done_q, done_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   gidx_q, gidx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   idx_q, idx_d;

   logic               sel_found;
   logic [PTR_W-1:0]   sel_idx;
   logic [PTR_W-1:0]   cand;
   logic [LEN_W-1:0]   sel_len;
   logic               more_leds;

   logic               load;
   logic [WORD_W-1:0]  load_word;
   logic               word_done;
   logic               shift_bit;

   // First requester at or after the pointer, walking upward with wrap.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NSTRAND; i++) begin
         cand = PTR_W'((32'(ptr_q) + i) % NSTRAND);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_len = '0;
      for (int unsigned k = 0; k < NSTRAND; k++) begin
         if (sel_idx == PTR_W'(k)) begin
            sel_len = len[LEN_W*k +: LEN_W];
         end
      end
   end

   assign more_leds = (({1'b0, idx_q} + 6'd1) < {1'b0, len_q});

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      done_d    = '0;
      ptr_d     = ptr_q;
      gidx_d    = gidx_q;
      len_d     = len_q;
      idx_d     = idx_q;
      load      = 1'b0;
      load_word = START_FRAME;
      pix_ready = 1'b0;
      case (state_q)
         StIdle: begin
            if (sel_found) begin
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               gidx_d           = sel_idx;
               len_d            = clamp_len(sel_len, LEN_LIM);
               idx_d            = '0;
               load             = 1'b1;
               load_word        = START_FRAME;
               state_d          = StStart;
            end
         end
         StStart: begin
            if (word_done) begin
               if (len_q == '0) begin
                  load      = 1'b1;
                  load_word = END_FRAME;
                  state_d   = StEnd;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               load      = 1'b1;
               load_word = pix_data;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (word_done) begin
               if (more_leds) begin
                  idx_d   = idx_q + 5'd1;
                  state_d = StFetch;
               end else begin
                  load      = 1'b1;
                  load_word = END_FRAME;
                  state_d   = StEnd;
               end
            end
         end
         StEnd: begin
            if (word_done) begin
               done_d  = grant_q;
               grant_d = '0;
               ptr_d   = (gidx_q == PTR_W'(NSTRAND - 1)) ? '0 : gidx_q + 1'b1;
               idx_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         done_q  <= '0;
         ptr_q   <= '0;
         gidx_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
      end
   end

   led_word_shifter #(
      .SCK_HALF (SCK_HALF)
   ) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .word      (load_word),
      .sck       (sck),
      .mosi      (shift_bit),
      .word_done (word_done)
   );

   assign grant     = grant_q;
   assign done      = done_q;
   assign pix_index = idx_q;
   assign mosi      = grant_q & {NSTRAND{shift_bit}};

endmodule
